// File: rtl/control_unit_pipe.sv
// control_unit_pipe
// -----------------------------------------------------------------------------
// Decode-stage control unit for the pipelined MIPS core. Decodes opcode/funct
// into a control word, holds that word in the ID/EX control register with
// stall/flush handling, and sequences the multi-cycle multiply/divide unit.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   id_valid        decode slot holds a real instruction
//   opcode, funct   instruction bits [31:26] and [5:0]
//   stall_in        downstream hold: ID/EX keeps its value (md_start excepted)
//   flush_in        squash: ID/EX loads a bubble
//   decode_stall    combinational: IF/ID must hold (HI/LO hazard)
//   ex_*            registered ID/EX control word
//   ex_md_start     registered one-cycle pulse for an accepted MULT*/DIV*
//   md_busy         registered: multiply/divide unit occupied
//   md_done         registered: pulse on the final busy cycle
//   dbg_state       registered FSM state (0 = IDLE, 1 = MD_BUSY)
//
// Handshake: an instruction in decode is consumed on a rising edge exactly
// when id_valid=1 and reset, flush_in, stall_in and decode_stall are all 0.
// -----------------------------------------------------------------------------
module control_unit_pipe #(
  parameter int FUNCT_W     = 6,
  parameter int ALU_OP_W    = 3,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [5:0]          opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                stall_in,
  input  logic                flush_in,
  output logic                decode_stall,
  output logic                ex_valid,
  output logic                ex_reg_write,
  output logic                ex_mem_to_reg,
  output logic                ex_mem_write,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic                ex_alu_src,
  output logic                ex_reg_dest,
  output logic                ex_branch,
  output logic                ex_jump,
  output logic                ex_jump_reg,
  output logic                ex_jump_link,
  output logic                ex_md_start,
  output logic                md_busy,
  output logic                md_done,
  output logic                dbg_state
);

  // Opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01; // BLTZ
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL funct codes
  localparam logic [FUNCT_W-1:0] FN_SLL   = FUNCT_W'(6'h00);
  localparam logic [FUNCT_W-1:0] FN_SRA   = FUNCT_W'(6'h03);
  localparam logic [FUNCT_W-1:0] FN_JR    = FUNCT_W'(6'h08);
  localparam logic [FUNCT_W-1:0] FN_MFHI  = FUNCT_W'(6'h10);
  localparam logic [FUNCT_W-1:0] FN_MFLO  = FUNCT_W'(6'h12);
  localparam logic [FUNCT_W-1:0] FN_MULT  = FUNCT_W'(6'h18);
  localparam logic [FUNCT_W-1:0] FN_MULTU = FUNCT_W'(6'h19);
  localparam logic [FUNCT_W-1:0] FN_DIV   = FUNCT_W'(6'h1A);
  localparam logic [FUNCT_W-1:0] FN_DIVU  = FUNCT_W'(6'h1B);
  localparam logic [FUNCT_W-1:0] FN_ADDU  = FUNCT_W'(6'h21);
  localparam logic [FUNCT_W-1:0] FN_SUBU  = FUNCT_W'(6'h23);
  localparam logic [FUNCT_W-1:0] FN_AND   = FUNCT_W'(6'h24);
  localparam logic [FUNCT_W-1:0] FN_OR    = FUNCT_W'(6'h25);
  localparam logic [FUNCT_W-1:0] FN_XOR   = FUNCT_W'(6'h26);
  localparam logic [FUNCT_W-1:0] FN_SLT   = FUNCT_W'(6'h2A);

  // ALU operation codes
  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_XOR = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_SLL = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] ALU_SRA = ALU_OP_W'(7);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  typedef struct packed {
    logic                reg_write;
    logic                mem_to_reg;
    logic                mem_write;
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_src;
    logic                reg_dest;
    logic                branch;
    logic                jump;
    logic                jump_reg;
    logic                jump_link;
    logic                md_start;
  } ctrl_t;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_MD_BUSY = 1'b1
  } state_t;

  ctrl_t            dec;
  ctrl_t            ex_q;
  logic             ex_valid_q;
  logic             known;
  logic             is_md;
  logic             is_div;
  logic             is_hilo_read;
  logic             md_issue;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             md_done_q, md_done_d;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  always_comb begin
    dec          = '0;
    known        = 1'b1;
    is_md        = 1'b0;
    is_div       = 1'b0;
    is_hilo_read = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        dec.reg_dest  = 1'b1;
        dec.reg_write = 1'b1;
        case (funct)
          FN_SLL:  begin dec.alu_op = ALU_SLL; dec.alu_src = 1'b1; end
          FN_SRA:  begin dec.alu_op = ALU_SRA; dec.alu_src = 1'b1; end
          FN_ADDU: dec.alu_op = ALU_ADD;
          FN_SUBU: dec.alu_op = ALU_SUB;
          FN_AND:  dec.alu_op = ALU_AND;
          FN_OR:   dec.alu_op = ALU_OR;
          FN_XOR:  dec.alu_op = ALU_XOR;
          FN_SLT:  dec.alu_op = ALU_SLT;
          FN_JR: begin
            dec.reg_write = 1'b0;
            dec.jump      = 1'b1;
            dec.jump_reg  = 1'b1;
          end
          FN_MFHI, FN_MFLO: is_hilo_read = 1'b1;
          FN_MULT, FN_MULTU: begin
            dec.reg_write = 1'b0;
            dec.md_start  = 1'b1;
            is_md         = 1'b1;
          end
          FN_DIV, FN_DIVU: begin
            dec.reg_write = 1'b0;
            dec.md_start  = 1'b1;
            is_md         = 1'b1;
            is_div        = 1'b1;
          end
          default: known = 1'b0;
        endcase
      end
      OP_REGIMM, OP_BEQ, OP_BNE: begin
        dec.branch = 1'b1;
        dec.alu_op = ALU_SUB;
      end
      OP_J:   dec.jump = 1'b1;
      OP_JAL: begin
        dec.jump      = 1'b1;
        dec.jump_link = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_ADDIU: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = ALU_ADD; end
      OP_ORI:   begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = ALU_OR;  end
      // LUI is the immediate shifted left by a fixed 16.
      OP_LUI:   begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = ALU_SLL; end
      OP_LW: begin
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
        dec.alu_op     = ALU_ADD;
      end
      OP_SW, OP_SB: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_ADD;
      end
      default: known = 1'b0;
    endcase
    // Anything not recognised becomes a bubble; it is never an error.
    if (!known) begin
      dec          = '0;
      is_md        = 1'b0;
      is_div       = 1'b0;
      is_hilo_read = 1'b0;
    end
  end

  // HI/LO hazard: hold decode until the final busy cycle, on which the
  // result is ready and a dependent read or new MD op may proceed.
  assign decode_stall = id_valid && md_busy && (is_md || is_hilo_read) &&
                        (cnt_q != '0);

  assign md_issue = id_valid && is_md && !flush_in && !stall_in && !decode_stall;

  // ---------------------------------------------------------------------------
  // Multiply/divide sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (md_issue) begin
      // A new op may start straight out of the final busy cycle of the last.
      state_d = S_MD_BUSY;
      cnt_d   = is_div ? DIV_LOAD : MULT_LOAD;
    end else if (state_q == S_MD_BUSY) begin
      if (cnt_q == '0) begin
        state_d = S_IDLE;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
    md_done_d = (state_d == S_MD_BUSY) && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      md_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      md_done_q <= md_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // ID/EX control register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
    end else if (flush_in) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
    end else if (stall_in) begin
      // Hold the word but never replay the start pulse.
      ex_q.md_start <= 1'b0;
    end else if (decode_stall) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      ex_q       <= id_valid ? dec : '0;
      ex_valid_q <= id_valid;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_reg_dest   = ex_q.reg_dest;
  assign ex_branch     = ex_q.branch;
  assign ex_jump       = ex_q.jump;
  assign ex_jump_reg   = ex_q.jump_reg;
  assign ex_jump_link  = ex_q.jump_link;
  assign ex_md_start   = ex_q.md_start;
  assign md_busy       = (state_q == S_MD_BUSY);
  assign md_done       = md_done_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Testbench for control_unit_pipe: directed steps with an expected queue of
// ID/EX control words and immediate assertions at every comparison point.
module tb_control_unit_pipe;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       stall_in;
  logic       flush_in;
  logic       decode_stall;
  logic       ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write;
  logic [2:0] ex_alu_op;
  logic       ex_alu_src, ex_reg_dest, ex_branch, ex_jump, ex_jump_reg;
  logic       ex_jump_link, ex_md_start, md_busy, md_done, dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [14:0] exp_q[$];

  // ALU codes as the core defines them
  localparam logic [2:0] A_ADD = 3'd0;
  localparam logic [2:0] A_SUB = 3'd1;

  control_unit_pipe dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode),
    .funct(funct), .stall_in(stall_in), .flush_in(flush_in),
    .decode_stall(decode_stall), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_write(ex_mem_write), .ex_alu_op(ex_alu_op),
    .ex_alu_src(ex_alu_src), .ex_reg_dest(ex_reg_dest),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jump_reg(ex_jump_reg),
    .ex_jump_link(ex_jump_link), .ex_md_start(ex_md_start),
    .md_busy(md_busy), .md_done(md_done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] mk(input logic v, input logic rw,
      input logic m2r, input logic mw, input logic [2:0] alu, input logic src,
      input logic rd, input logic br, input logic j, input logic jr,
      input logic jl, input logic mds);
    return {v, rw, m2r, mw, alu, src, rd, br, j, jr, jl, mds};
  endfunction

  function automatic logic [14:0] obs_word();
    return {ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_alu_op,
            ex_alu_src, ex_reg_dest, ex_branch, ex_jump, ex_jump_reg,
            ex_jump_link, ex_md_start};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn);
    id_valid = v;
    opcode   = op;
    funct    = fn;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard pop/compare of the ID/EX word
  task automatic check_ex(input string tag);
    logic [14:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: observed %0h expected <empty queue>", tag, obs_word());
    end else begin
      e = exp_q.pop_front();
      check(tag, {17'd0, obs_word()}, {17'd0, e});
    end
  endtask

  localparam logic [14:0] BUBBLE = 15'd0;

  initial begin
    logic [14:0] w_addiu, w_mult;
    int busy_cnt, done_cnt, done_at;

    w_addiu = mk(1,1,0,0,A_ADD,1,0,0,0,0,0,0);
    w_mult  = mk(1,0,0,0,A_ADD,0,1,0,0,0,0,1);

    reset = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
    drive(1, 6'h23, 6'h00);
    #1;
    exp_q.push_back(BUBBLE);
    tick(); tick();
    check_ex("reset_word");
    check("reset_busy", {31'd0, md_busy}, 32'd0);
    check("reset_done", {31'd0, md_done}, 32'd0);
    check("reset_state", {31'd0, dbg_state}, 32'd0);

    // LW on first edge after release
    reset = 1'b0;
    exp_q.push_back(mk(1,1,1,0,A_ADD,1,0,0,0,0,0,0));
    tick(); check_ex("lw");

    drive(1, 6'h2B, 6'h00);
    exp_q.push_back(mk(1,0,0,1,A_ADD,1,0,0,0,0,0,0));
    tick(); check_ex("sw");

    drive(1, 6'h03, 6'h00);
    exp_q.push_back(mk(1,1,0,0,A_ADD,0,0,0,1,0,1,0));
    tick(); check_ex("jal");

    drive(1, 6'h00, 6'h08);
    exp_q.push_back(mk(1,0,0,0,A_ADD,0,1,0,1,1,0,0));
    tick(); check_ex("jr");

    drive(1, 6'h04, 6'h00);
    exp_q.push_back(mk(1,0,0,0,A_SUB,0,0,1,0,0,0,0));
    tick(); check_ex("beq");

    drive(1, 6'h3F, 6'h00);
    exp_q.push_back(mk(1,0,0,0,A_ADD,0,0,0,0,0,0,0));
    tick(); check_ex("unknown_op");

    // MULT then MFLO held in decode
    drive(1, 6'h00, 6'h18);
    exp_q.push_back(w_mult);
    tick(); check_ex("mult_issue");
    drive(1, 6'h00, 6'h12);
    #1;
    for (int i = 1; i <= 3; i++) begin
      check("mflo_stall", {31'd0, decode_stall}, 32'd1);
      check("mult_busy", {31'd0, md_busy}, 32'd1);
      check("mult_nodone", {31'd0, md_done}, 32'd0);
      exp_q.push_back(BUBBLE);
      tick(); check_ex("stall_bubble");
    end
    check("mflo_release", {31'd0, decode_stall}, 32'd0);
    check("mult_busy4", {31'd0, md_busy}, 32'd1);
    check("mult_done4", {31'd0, md_done}, 32'd1);
    exp_q.push_back(mk(1,1,0,0,A_ADD,0,1,0,0,0,0,0));
    tick(); check_ex("mflo_issue");
    check("mult_idle", {31'd0, md_busy}, 32'd0);
    check("mult_done_clr", {31'd0, md_done}, 32'd0);
    check("mult_state_idle", {31'd0, dbg_state}, 32'd0);

    // DIV with independent ADDIUs flowing
    drive(1, 6'h00, 6'h1A);
    exp_q.push_back(mk(1,0,0,0,A_ADD,0,1,0,0,0,0,1));
    tick(); check_ex("div_issue");
    busy_cnt = 0; done_cnt = 0;
    drive(1, 6'h09, 6'h00);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("addiu_nostall", {31'd0, decode_stall}, 32'd0);
      if (md_busy) busy_cnt++;
      if (md_done) done_cnt++;
      exp_q.push_back(w_addiu);
      tick(); check_ex("addiu_flow");
    end
    drive(0, 6'h00, 6'h00);
    for (int g = 0; g < 100 && md_busy; g++) begin
      busy_cnt++;
      if (md_done) done_cnt++;
      tick();
    end
    check("div_busy_len", busy_cnt, 32'd32);
    check("div_done_cnt", done_cnt, 32'd1);

    // MULT then flush on next edge: op keeps running
    drive(1, 6'h00, 6'h19);
    exp_q.push_back(w_mult);
    tick(); check_ex("multu_issue");
    busy_cnt = 1; done_cnt = 0; done_at = 0;
    check("multu_busy1", {31'd0, md_busy}, 32'd1);
    drive(1, 6'h09, 6'h00);
    flush_in = 1'b1;
    exp_q.push_back(BUBBLE);
    tick(); check_ex("flush_bubble");
    flush_in = 1'b0;
    drive(0, 6'h00, 6'h00);
    for (int g = 0; g < 100 && md_busy; g++) begin
      busy_cnt++;
      if (md_done) begin done_cnt++; done_at = busy_cnt; end
      tick();
    end
    check("flush_busy_len", busy_cnt, 32'd4);
    check("flush_done_cnt", done_cnt, 32'd1);
    check("flush_done_at", done_at, 32'd4);

    // Flush on the issue edge: op not accepted
    drive(1, 6'h00, 6'h18);
    flush_in = 1'b1;
    exp_q.push_back(BUBBLE);
    tick(); check_ex("flush_issue_bubble");
    flush_in = 1'b0;
    check("flush_issue_idle", {31'd0, md_busy}, 32'd0);

    // Stall holds the word; stall+flush loads a bubble
    drive(1, 6'h09, 6'h00);
    exp_q.push_back(w_addiu);
    tick(); check_ex("addiu_load");
    drive(1, 6'h23, 6'h00);
    stall_in = 1'b1;
    exp_q.push_back(w_addiu);
    tick(); check_ex("stall_hold");
    drive(1, 6'h09, 6'h00);
    flush_in = 1'b1;
    exp_q.push_back(BUBBLE);
    tick(); check_ex("stall_flush");
    stall_in = 1'b0; flush_in = 1'b0;

    // md_start not held by stall, then back-to-back MULT on the final cycle
    drive(1, 6'h00, 6'h18);
    exp_q.push_back(w_mult);
    tick(); check_ex("mult2_issue");
    stall_in = 1'b1;
    exp_q.push_back(mk(1,0,0,0,A_ADD,0,1,0,0,0,0,0));
    tick(); check_ex("stall_no_start");
    stall_in = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("b2b_stall", {31'd0, decode_stall}, 32'd1);
      exp_q.push_back(BUBBLE);
      tick(); check_ex("b2b_bubble");
    end
    check("b2b_release", {31'd0, decode_stall}, 32'd0);
    check("b2b_done", {31'd0, md_done}, 32'd1);
    exp_q.push_back(w_mult);
    tick(); check_ex("b2b_issue");
    check("b2b_busy", {31'd0, md_busy}, 32'd1);
    check("b2b_state", {31'd0, dbg_state}, 32'd1);
    check("b2b_nodone", {31'd0, md_done}, 32'd0);

    // Reset in the middle of MD_BUSY
    drive(0, 6'h00, 6'h00);
    reset = 1'b1;
    exp_q.push_back(BUBBLE);
    tick(); check_ex("midreset_word");
    check("midreset_busy", {31'd0, md_busy}, 32'd0);
    check("midreset_state", {31'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    tick();
    check("midreset_stays_idle", {31'd0, md_busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
